serial_parity_rx: RTL
=====================

// Module: serial_parity_rx
// PURPOSE
//  Receiver and checker for the serial parity-protected link; the generator end is the parity TX block.
//  Deserialises one frame per transaction: start(0), DATA_W data bits LSB first, parity bit, stop(1).
//  Presents the word with a one-cycle valid strobe, a parity-error flag and a framing-error flag.
//  Sits between the bit-sampling front end (which supplies bit_en) and the word-level consumer.
// PARAMETERS
//  DATA_W      8  data bits per frame (>=2)
//  ODD_PARITY  0  0: even parity (XOR of data+parity == 0); 1: odd parity (XOR == 1)
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  rst_n       in   1       reset, synchronous, active-low
//  sin         in   1       serial line, idle high; sampled only when bit_en=1
//  bit_en      in   1       one-cycle sample strobe, one per bit period
//  data_out    out  DATA_W  last received word; held until the next frame completes
//  data_valid  out  1       one-cycle pulse: data_out/parity_err/frame_err updated
//  parity_err  out  1       parity mismatch on the last frame; held with data_out
//  frame_err   out  1       stop bit sampled as 0 on the last frame; held with data_out
//  busy        out  1       1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): state=IDLE, data_out=0, data_valid=0, parity_err=0,
//   frame_err=0, busy=0, shift reg/bit counter/parity accumulator cleared. Reset mid-frame
//   discards the partial frame; no data_valid is produced for it.
//  bit_en=0: no state change; sin is ignored. data_valid is forced 0 in every cycle without a completion.
//  FSM (advances only on edges with bit_en=1):
//   IDLE   : sin=0 -> DATA; clear cnt, acc, shreg. sin=1 -> stay.
//   DATA   : shreg <= {sin, shreg[DATA_W-1:1]}; acc <= acc ^ sin; cnt <= cnt+1;
//            cnt==DATA_W-1 -> PARITY.
//   PARITY : perr_q <= acc ^ sin ^ ODD_PARITY -> STOP.
//   STOP   : data_out <= shreg; parity_err <= perr_q; frame_err <= ~sin; data_valid <= 1 -> IDLE.
//  Latency: data_valid is high in the cycle after the edge that samples the stop bit; it lasts exactly one cycle.
//  Errored frames still complete: data_valid pulses with the corresponding flag set; the consumer decides.
//  Back-to-back frames: the first bit_en after STOP is evaluated in IDLE; a 0 starts the next frame at once.
//  A line held low in IDLE starts a new frame on every qualifying bit_en (no glitch filter in this block).
//  cnt width = $clog2(DATA_W); no wrap occurs because DATA exits at DATA_W-1.
//  busy is registered: it rises the cycle after the start bit and falls the cycle after the stop bit.
// STRUCTURE
//  Shared include serial_parity_defs.vh: FSM state localparams (IDLE/DATA/PARITY/STOP, 2 bits),
//   START_BIT=1'b0, STOP_BIT=1'b1; reused by the parity TX block.
//  One natural sub-module: rx_shift_acc (shift register + running XOR accumulator + bit counter,
//   enabled by the FSM); the FSM and output registers stay in the top.
// TESTING
//  1 Even, bit_en every 4 clocks: 0, 1,0,1,0,0,1,0,1, 0, 1 -> data_out=8'hA5, data_valid 1 cycle, both errs=0.
//  2 Same frame with parity bit=1 -> data_out=8'hA5, parity_err=1, frame_err=0.
//  3 Frame 0x3C (parity 0), stop bit=0 -> data_out=8'h3C, frame_err=1, parity_err=0.
//  4 rst_n=0 for 1 cycle after 4 data bits -> busy=0, no data_valid; next frame 0x3C -> received clean.
//  5 Random bit_en gaps (0-7 clocks) with sin toggling between strobes -> result identical to case 1.
//  6 ODD_PARITY=1, frames 0x01/parity 0 and 0x00/parity 1 back-to-back -> two pulses, parity_err=0 on both.

Source files
------------

// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity link (RX side and TX block).
// FSM state encodings, line levels and the parity-check rule.
package serial_parity_rx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Parity error flag: XOR of data bits, parity bit and the odd/even
    // selector is 1 when the frame violates the configured parity.
    function automatic logic parity_err_of(input logic acc, input logic pbit,
                                           input logic odd);
        return acc ^ pbit ^ odd;
    endfunction

endpackage

// File: rtl/serial_parity_rx_shift_acc.sv
// Data-phase datapath: LSB-first shift register, running XOR of the
// received data bits and the data-bit counter. The FSM decides when to
// clear and when to shift; this block only holds the state.
module rx_shift_acc
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_shreg,
    output logic              o_acc,
    output logic              o_last
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_shreg;
    logic              r_acc;
    logic [CW-1:0]     r_cnt;

    // Clear on frame start, otherwise shift one bit in per data strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
        end else if (i_clr) begin
            r_shreg <= '0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shreg <= {i_bit, r_shreg[DATA_W-1:1]};
            r_acc   <= r_acc ^ i_bit;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_shreg = r_shreg;
    assign o_acc   = r_acc;
    // Counter reaches DATA_W-1 on the final data bit, so it never wraps.
    assign o_last  = (r_cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/serial_parity_rx.sv
// Serial parity-protected frame receiver:
// start(0), DATA_W data bits LSB first, parity bit, stop(1).
// Delivers the word with a one-cycle valid strobe plus parity/framing flags.
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              bit_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    logic [1:0]        r_state;
    logic              r_perr_q;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_parity_err;
    logic              r_frame_err;
    logic              r_busy;

    logic              w_clr;
    logic              w_shift;
    logic [DATA_W-1:0] w_shreg;
    logic              w_acc;
    logic              w_last;

    assign w_clr   = bit_en && (r_state == ST_IDLE) && (sin == START_BIT);
    assign w_shift = bit_en && (r_state == ST_DATA);

    rx_shift_acc #(
        .DATA_W (DATA_W)
    ) u_shift_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_clr),
        .i_shift (w_shift),
        .i_bit   (sin),
        .o_shreg (w_shreg),
        .o_acc   (w_acc),
        .o_last  (w_last)
    );

    // Frame FSM and output registers; everything advances only on bit_en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_perr_q     <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (sin == START_BIT) begin
                            r_state <= ST_DATA;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (w_last) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_perr_q <= parity_err_of(w_acc, sin, ODD_PARITY);
                        r_state  <= ST_STOP;
                    end
                    ST_STOP: begin
                        // Errored frames still complete; the consumer decides.
                        r_data_out   <= w_shreg;
                        r_parity_err <= r_perr_q;
                        r_frame_err  <= (sin != STOP_BIT);
                        r_data_valid <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign busy       = r_busy;

endmodule
